tea_deserializer: RTL
=====================

TEA_DESERIALIZER -- requirements
Module: tea_deserializer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named as follows.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous active-high reset.
REQ-002 The block SHALL provide these input ports from the serial encrypt stage.
- in_valid  input  1  one serial bit pair present this cycle.
- v0_in  input  1  current ciphertext bit of word v0, MSB first.
- v1_in  input  1  current ciphertext bit of word v1, MSB first.
- in_bits  input  6  index of the current bit pair, 0..31.
REQ-003 The block SHALL provide these output ports to the consumer.
- out_valid  output  1  held word pair available.
- out_ready  input  1  consumer accepts the word pair.
- v0_word  output  32  assembled v0 ciphertext.
- v1_word  output  32  assembled v1 ciphertext.
- sync_err  output  1  one-cycle pulse on an index mismatch.

Function
REQ-004 The block SHALL use an assembly FSM with two states:
- IDLE: bit counter cnt = 0, no partial word.
- SHIFT: 1..31 bits received.
REQ-005 On in_valid=1 with in_bits==cnt, the block SHALL shift v0_in and v1_in into the LSB of their shift registers and increment cnt.
REQ-006 Accepting bit 31 SHALL complete the word pair, set cnt to 0 and return the FSM to IDLE.
REQ-007 The block SHALL ignore cycles with in_valid=0; cnt and the shift registers hold.
REQ-008 On in_valid=1 with in_bits!=cnt, the block SHALL pulse sync_err for one cycle and discard the partial word.
- If in_bits==0, the current bits SHALL be accepted as bit 0 of a new word (cnt becomes 1).
- Otherwise cnt SHALL return to 0 and the FSM to IDLE.
REQ-009 A single holding register SHALL drive v0_word, v1_word and out_valid.
REQ-010 A completed pair SHALL load the holding register on the same clock edge that accepts bit 31, so out_valid rises in the cycle after that edge (latency 1).
REQ-011 A transfer SHALL occur when out_valid=1 and out_ready=1.
- out_valid SHALL fall after the transfer unless a new pair loads on the same edge, in which case out_valid stays 1 with the new data.
REQ-012 While out_valid=1 and out_ready=0:
- v0_word and v1_word SHALL remain stable.
- A newly completed pair SHALL be dropped; the holding register is never overwritten.
REQ-013 Assembly SHALL continue independently of holding-register occupancy; the block has no input backpressure.
REQ-014 v0_word and v1_word SHALL be exactly 32 bits; the first-received bit lands in bit 31.

Reset
REQ-015 Reset SHALL act asynchronously and clear all state:
- FSM=IDLE, cnt=0, shift registers=0.
- out_valid=0, v0_word=0, v1_word=0, sync_err=0.
- overflow=0 when compiled in.
REQ-016 Reset asserted mid-word SHALL discard the partial word.
- After deassertion, the first accepted bit SHALL be the one with in_bits==0.

Configuration
REQ-017 Macro TEA_DESER_OVERFLOW_EN, when defined, SHALL add two ports:
- overflow  output  1  sticky; set when REQ-012 drops a pair.
- ovf_clr  input  1  synchronous clear of overflow; a set in the same cycle wins.
REQ-018 Without TEA_DESER_OVERFLOW_EN, neither port SHALL exist and dropped pairs SHALL be silent; all other behaviour is identical.

Structure
REQ-019 Package tea_pkg SHALL hold:
- WORD_W=32, IDX_W=6.
- the assembly FSM state typedef (IDLE, SHIFT).
REQ-020 Sub-module tea_shift32 (32-bit MSB-first shift register with shift enable and clear) SHALL be instantiated twice, once for v0 and once for v1.

Verification
REQ-021 Scenario 1: after reset, send 32 in-order bit pairs of v0=0xDEADBEEF, v1=0x01234567 with out_ready=1.
- Required: out_valid=1 one cycle after bit 31, with exactly those words; sync_err never pulses.
REQ-022 Scenario 2: send pattern 0xA5A5A5A5/0x5A5A5A5A with in_valid toggling every other cycle.
- Required: same words delivered; completion is 63 cycles after bit 0.
REQ-023 Scenario 3: send pair 0x11111111/0x22222222 with out_ready=0, then pair 0x33333333/0x44444444.
- Required: the held value remains 0x11111111/0x22222222.
- Required: overflow=1 (with macro defined).
- Required: raising out_ready transfers the first pair and out_valid then falls.
REQ-024 Scenario 4: hold out_ready=1 so the holding register is read out on the same edge the next pair (0x55555555/0x66666666) completes.
- Required: out_valid stays 1 and the new pair appears.
REQ-025 Scenario 5: after bit 9, present in_bits=17.
- Required: sync_err pulses and the partial word is discarded.
- Required: a full in-order resend of 0xCAFEF00D/0x0BADF00D is delivered correctly.
REQ-026 Scenario 6: assert reset at bit 20, then resend 0x0F0F0F0F/0xF0F0F0F0.
- Required: outputs are zero during reset, and exactly the resent words are delivered.

Source files
------------

// File: rtl/tea_pkg.sv
// tea_pkg: shared widths and assembly FSM state type for the TEA deserializer
package tea_pkg;
    localparam int WORD_W = 32;
    localparam int IDX_W  = 6;
    typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/tea_shift32.sv
// tea_shift32: 32-bit MSB-first shift register with shift enable and synchronous clear
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   clr_i        discard contents; combined with en_i the new bit starts a fresh word
//   en_i         shift d_i into the LSB
//   d_i          serial input bit
//   nxt_o        register contents including this cycle's shift, so a word whose
//                last bit arrives now can be captured on the same edge
module tea_shift32
    import tea_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              d_i,
    output logic [WORD_W-1:0] nxt_o
);
    logic [WORD_W-1:0] sr_q, sr_d, base;

    always_comb begin
        base = clr_i ? '0 : sr_q;
        sr_d = en_i ? {base[WORD_W-2:0], d_i} : base;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sr_q <= '0;
        else       sr_q <= sr_d;
    end

    assign nxt_o = sr_d;
endmodule

// File: rtl/tea_deserializer.sv
// tea_deserializer: assembles serial TEA ciphertext bit pairs into 32-bit words with a single output holding register
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   in_valid            a serial bit pair is present this cycle
//   v0_in, v1_in        current ciphertext bits, MSB first
//   in_bits             index of the current bit pair (0..31)
//   out_valid           holding register contains a word pair
//   out_ready           consumer accepts the held pair
//   v0_word, v1_word    held word pair
//   sync_err            one-cycle pulse after an index mismatch
// Optional (macro TEA_DESER_OVERFLOW_EN):
//   ovf_clr             synchronous clear of overflow (a simultaneous set wins)
//   overflow            sticky flag, set when a completed pair is dropped
module tea_deserializer
    import tea_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              v0_in,
    input  logic              v1_in,
    input  logic [IDX_W-1:0]  in_bits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] v0_word,
    output logic [WORD_W-1:0] v1_word,
    output logic              sync_err
`ifdef TEA_DESER_OVERFLOW_EN
    ,
    input  logic              ovf_clr,
    output logic              overflow
`endif
);
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              match, mism, restart, last;
    logic              shift_en, sr_clr, complete, transfer, load;
    logic [WORD_W-1:0] v0_nxt, v1_nxt;
    logic              valid_q, valid_d, serr_q;
    logic [WORD_W-1:0] v0_q, v0_d, v1_q, v1_d;

    assign match   = in_valid && (in_bits == cnt_q);
    assign mism    = in_valid && (in_bits != cnt_q);
    // a mismatching index 0 is the start of a fresh word, not just noise
    assign restart = mism && (in_bits == '0);
    assign last    = (state_q == SHIFT) && (cnt_q == IDX_W'(WORD_W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cnt_d   = match ? (last ? '0 : cnt_q + 1'b1) : mism ? IDX_W'(restart) : cnt_q;
        state_d = (cnt_d == '0) ? IDLE : SHIFT;
    end

    always_comb begin
        shift_en = match || restart;
        sr_clr   = mism;
        complete = match && last;
        transfer = valid_q && out_ready;
        // a finished pair only lands if the holding register is empty or draining this edge
        load     = complete && (!valid_q || out_ready);
    end

    tea_shift32 u_sr_v0 (
        .clk   (clk),
        .reset (reset),
        .clr_i (sr_clr),
        .en_i  (shift_en),
        .d_i   (v0_in),
        .nxt_o (v0_nxt)
    );

    tea_shift32 u_sr_v1 (
        .clk   (clk),
        .reset (reset),
        .clr_i (sr_clr),
        .en_i  (shift_en),
        .d_i   (v1_in),
        .nxt_o (v1_nxt)
    );

    always_comb begin
        valid_d = load ? 1'b1 : transfer ? 1'b0 : valid_q;
        v0_d    = load ? v0_nxt : v0_q;
        v1_d    = load ? v1_nxt : v1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            v0_q    <= '0;
            v1_q    <= '0;
            serr_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            serr_q  <= mism;
        end
    end

    assign out_valid = valid_q;
    assign v0_word   = v0_q;
    assign v1_word   = v1_q;
    assign sync_err  = serr_q;

`ifdef TEA_DESER_OVERFLOW_EN
    logic drop, ovf_q, ovf_d;

    assign drop = complete && valid_q && !out_ready;

    always_comb ovf_d = drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign overflow = ovf_q;
`endif
endmodule
